// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I instruction views, fetch FIFO entry type and shared constants
package rv32i;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } r_type_t;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } i_type_t;

  typedef struct packed {
    logic [6:0] imm_hi;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm_lo;
    logic [6:0] opcode;
  } s_type_t;

  typedef struct packed {
    logic [19:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } u_type_t;

  typedef union packed {
    logic [31:0] raw;
    r_type_t     r;
    i_type_t     i;
    s_type_t     s;
    u_type_t     u;
  } rv32i_inst_u;

  typedef struct packed {
    logic [31:0] pc;
    rv32i_inst_u instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous {pc, instr} FIFO; flush overrides push and pop
module fetch_fifo
  import rv32i::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC, imem requests, instruction FIFO, redirect flush
// Define IFETCH_MISALIGN_CHECK_EN to fault on misaligned redirect targets.
module fetch_unit
  import rv32i::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output rv32i_inst_u instr,
  output logic [31:0] instr_pc,
  output logic        fetch_fault
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc;
  logic [31:0]      rsp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   in_use;
  logic             fault;
  logic             req_fire;
  logic             rsp_keep;
  logic             pop;
  logic [31:0]      target;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  // Buffered plus in-flight words never exceed DEPTH, so every response has a slot.
  assign in_use         = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !redirect_valid && !fault && (in_use < (CNT_W+1)'(DEPTH));
  assign imem_addr      = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && !redirect_valid && (drop == '0) && !fault;
  assign pop            = instr_valid && instr_ready;
  assign target         = word_align(redirect_pc);
  assign push_entry     = {rsp_pc, imem_rsp_data};

  // rsp_pc is the PC of the next response that will be kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= target;
      rsp_pc      <= target;
      outstanding <= outstanding - CNT_W'(imem_rsp_valid);
      drop        <= outstanding - CNT_W'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (rsp_keep) rsp_pc <= rsp_pc + 32'd4;
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      if (imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
    end
  end

`ifdef IFETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault <= 1'b0;
    end else if (redirect_valid) begin
      fault <= |redirect_pc[1:0];
    end
  end
`else
  assign fault = 1'b0;
`endif

  assign fetch_fault = fault;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rsp_keep),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect_valid),
    .count    (count),
    .head     (head)
  );

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against an epoch-based model
module tb_fetch_unit;
  import rv32i::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 4;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  rv32i_inst_u instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] bufq[$];
  int          epoch, cyc, last_due, lat_min, lat_max;
  logic [31:0] next_req;
  bit          fault_m;
  int          errors, checks;

  bit          d_redirect, d_iready, d_qready;
  logic [31:0] d_target;

  logic        obs_ivalid, obs_rvalid, obs_fault;
  logic [31:0] obs_pc, obs_instr, obs_addr;
  logic        exp_ivalid, exp_rvalid, exp_fault;
  logic [31:0] exp_pc, exp_instr, exp_addr;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ RV32I_NOP;
  endfunction

  // One clock: drive inputs at the falling edge, observe, then advance the model across the rising edge.
  task automatic step();
    mreq_t h;
    int    due;
    bit    fire, popd, rsp;
    redirect_valid = d_redirect;
    redirect_pc    = d_target;
    instr_ready    = d_iready;
    imem_req_ready = d_qready;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    obs_ivalid = instr_valid; obs_pc = instr_pc; obs_instr = instr.raw;
    obs_rvalid = imem_req_valid; obs_addr = imem_addr; obs_fault = fetch_fault;
    exp_ivalid = (bufq.size() != 0);
    exp_pc     = exp_ivalid ? bufq[0] : 32'h0;
    exp_instr  = exp_ivalid ? word_of(bufq[0]) : 32'h0;
    exp_rvalid = !d_redirect && !fault_m && ((memq.size() + bufq.size()) < DEPTH);
    exp_addr   = next_req;
    exp_fault  = fault_m;
    fire = obs_rvalid && d_qready;
    popd = obs_ivalid && d_iready;
    rsp  = imem_rsp_valid;
    if (d_redirect) begin
      bufq.delete();
      epoch++;
      if (rsp) void'(memq.pop_front());
      next_req = d_target & ~32'h3;
`ifdef IFETCH_MISALIGN_CHECK_EN
      fault_m = (d_target[1:0] != 2'b00);
`else
      fault_m = 1'b0;
`endif
    end else begin
      if (popd && bufq.size() > 0) void'(bufq.pop_front());
      if (rsp) begin
        h = memq.pop_front();
        if (h.ep == epoch) bufq.push_back(h.addr);
      end
      if (fire) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        memq.push_back('{addr: obs_addr, ep: epoch, due: due});
        next_req = next_req + 32'd4;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    d_redirect = 1'b0; d_target = 32'h0; d_iready = 1'b1; d_qready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    memq.delete(); bufq.delete();
    epoch = 0; cyc = 0; last_due = -1; next_req = RST_PC; fault_m = 1'b0;
    lat_min = 1; lat_max = 1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RST_PC); end
    checks++; if (instr_valid !== 1'b0 || instr.raw !== 32'h0 || instr_pc !== 32'h0) begin
      errors++; $display("FAIL reset_instr got v=%b i=%h pc=%h exp 0/0/0", instr_valid, instr.raw, instr_pc); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
    do_reset();
    for (int i = 0; i < 5; i++) step();
    // Reset mid-operation clears the FIFO and request without waiting for a clock edge.
    rst = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== RST_PC) begin
      errors++; $display("FAIL reset_midop got req=%b iv=%b addr=%h exp 0/0/%h", imem_req_valid, instr_valid, imem_addr, RST_PC); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    int first_valid;
    do_reset();
    first_valid = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++; if (obs_rvalid !== 1'b1 || obs_addr !== RST_PC + 32'(4 * i)) begin
        errors++; $display("FAIL stream_req i=%0d got v=%b a=%h exp 1/%h", i, obs_rvalid, obs_addr, RST_PC + 32'(4 * i)); end
      if (obs_ivalid && first_valid < 0) first_valid = i;
      if (i >= 2) begin
        checks++; if (obs_ivalid !== 1'b1 || obs_pc !== RST_PC + 32'(4 * (i - 2)) || obs_instr !== word_of(RST_PC + 32'(4 * (i - 2)))) begin
          errors++; $display("FAIL stream_instr i=%0d got v=%b pc=%h exp pc=%h", i, obs_ivalid, obs_pc, RST_PC + 32'(4 * (i - 2))); end
      end
    end
    checks++; if (first_valid != 2) begin errors++; $display("FAIL stream_latency got=%0d exp=2", first_valid); end
  endtask

  task automatic test_backpressure();
    int fires, pops;
    do_reset();
    d_iready = 1'b0;
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_rvalid && d_qready) fires++;
    end
    checks++; if (fires != DEPTH) begin errors++; $display("FAIL bp_fires got=%0d exp=%0d", fires, DEPTH); end
    checks++; if (obs_rvalid !== 1'b0) begin errors++; $display("FAIL bp_req_low got=%b exp=0", obs_rvalid); end
    d_iready = 1'b1;
    pops = 0;
    for (int i = 0; i < 20 && pops < DEPTH; i++) begin
      step();
      if (obs_ivalid) begin
        checks++; if (obs_pc !== RST_PC + 32'(4 * pops) || obs_instr !== word_of(RST_PC + 32'(4 * pops))) begin
          errors++; $display("FAIL bp_order k=%0d got pc=%h exp=%h", pops, obs_pc, RST_PC + 32'(4 * pops)); end
        pops++;
      end
    end
    checks++; if (pops != DEPTH) begin errors++; $display("FAIL bp_drain got=%0d exp=%0d", pops, DEPTH); end
  endtask

  task automatic test_redirect_inflight();
    int k;
    do_reset();
    lat_min = 3; lat_max = 3;
    step(); step();
    d_redirect = 1'b1; d_target = 32'h0000_0200;
    step();
    d_redirect = 1'b0;
    k = -1;
    for (int i = 0; i < 20 && k < 0; i++) begin
      step();
      if (obs_ivalid) begin
        k = i;
        checks++; if (obs_pc !== 32'h200 || obs_instr !== word_of(32'h200)) begin
          errors++; $display("FAIL redir_first got pc=%h i=%h exp pc=00000200", obs_pc, obs_instr); end
      end
    end
    checks++; if (k != 4) begin errors++; $display("FAIL redir_latency got=%0d exp=4", k); end
  endtask

  task automatic test_redirect_rsp_pop();
    do_reset();
    for (int i = 0; i < 4; i++) step();
    d_redirect = 1'b1; d_target = 32'h0000_0240;
    step();
    d_redirect = 1'b0;
    checks++; if (obs_ivalid !== 1'b1 || obs_rvalid !== 1'b0) begin
      errors++; $display("FAIL rrp_cycle got iv=%b req=%b exp 1/0", obs_ivalid, obs_rvalid); end
    step();
    checks++; if (obs_ivalid !== 1'b0 || obs_rvalid !== 1'b1 || obs_addr !== 32'h240) begin
      errors++; $display("FAIL rrp_next got iv=%b req=%b a=%h exp 0/1/00000240", obs_ivalid, obs_rvalid, obs_addr); end
    step();
    checks++; if (obs_ivalid !== 1'b0) begin errors++; $display("FAIL rrp_empty got=%b exp=0", obs_ivalid); end
    step();
    checks++; if (obs_ivalid !== 1'b1 || obs_pc !== 32'h240) begin
      errors++; $display("FAIL rrp_deliver got iv=%b pc=%h exp 1/00000240", obs_ivalid, obs_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    d_redirect = 1'b1; d_target = 32'hFFFF_FFFC;
    step();
    d_redirect = 1'b0;
    step();
    checks++; if (obs_rvalid !== 1'b1 || obs_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_req0 got v=%b a=%h exp 1/fffffffc", obs_rvalid, obs_addr); end
    step();
    checks++; if (obs_rvalid !== 1'b1 || obs_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_req1 got v=%b a=%h exp 1/00000000", obs_rvalid, obs_addr); end
    step();
    checks++; if (obs_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0 got=%h exp=fffffffc", obs_pc); end
    step();
    checks++; if (obs_pc !== 32'h0 || obs_ivalid !== 1'b1) begin
      errors++; $display("FAIL wrap_pc1 got v=%b pc=%h exp 1/00000000", obs_ivalid, obs_pc); end
  endtask

  task automatic test_misalign();
    do_reset();
    lat_min = 2; lat_max = 2;
    step(); step(); step();
    d_redirect = 1'b1; d_target = 32'h0000_0202;
    step();
    d_redirect = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (obs_fault !== 1'b1 || obs_rvalid !== 1'b0 || obs_ivalid !== 1'b0) begin
        errors++; $display("FAIL mis_hold i=%0d got f=%b req=%b iv=%b exp 1/0/0", i, obs_fault, obs_rvalid, obs_ivalid); end
    end
    d_redirect = 1'b1; d_target = 32'h0000_0300;
    step();
    d_redirect = 1'b0;
    step();
    checks++; if (obs_fault !== 1'b0 || obs_rvalid !== 1'b1 || obs_addr !== 32'h300) begin
      errors++; $display("FAIL mis_clear got f=%b req=%b a=%h exp 0/1/00000300", obs_fault, obs_rvalid, obs_addr); end
`else
    step();
    checks++; if (obs_fault !== 1'b0 || obs_rvalid !== 1'b1 || obs_addr !== 32'h200) begin
      errors++; $display("FAIL mis_ignore got f=%b req=%b a=%h exp 0/1/00000200", obs_fault, obs_rvalid, obs_addr); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        do_reset();
        lat_min = 1; lat_max = 4;
      end
      d_qready   = ($urandom_range(3, 0) != 0);
      d_iready   = ($urandom_range(2, 0) != 0);
      d_redirect = ($urandom_range(24, 0) == 0);
      d_target   = $urandom & ~32'h3;
`ifdef IFETCH_MISALIGN_CHECK_EN
      if ($urandom_range(3, 0) == 0) d_target[1:0] = 2'($urandom_range(3, 1));
`else
      d_target[1:0] = 2'($urandom_range(3, 0));
`endif
      step();
      d_redirect = 1'b0;
      checks++; if (obs_ivalid !== exp_ivalid || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
        errors++; $display("FAIL rand_instr cyc=%0d got v=%b pc=%h i=%h exp v=%b pc=%h i=%h", cyc, obs_ivalid, obs_pc, obs_instr, exp_ivalid, exp_pc, exp_instr); end
      checks++; if (obs_rvalid !== exp_rvalid) begin
        errors++; $display("FAIL rand_req_valid cyc=%0d got=%b exp=%b", cyc, obs_rvalid, exp_rvalid); end
      if (exp_rvalid) begin
        checks++; if (obs_addr !== exp_addr) begin
          errors++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", cyc, obs_addr, exp_addr); end
      end
      checks++; if (obs_fault !== exp_fault) begin
        errors++; $display("FAIL rand_fault cyc=%0d got=%b exp=%b", cyc, obs_fault, exp_fault); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
    d_redirect = 1'b0; d_target = 32'h0; d_iready = 1'b1; d_qready = 1'b1;
    lat_min = 1; lat_max = 1; last_due = -1; cyc = 0; epoch = 0; next_req = RST_PC; fault_m = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_rsp_pop();
    test_wrap();
    test_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
